izh_step_scheduler: RTL and testbench

//  Time-multiplexes one shared Izhikevich derivative datapath (calc_dv/calc_dw pair) across NEURONS neurons.

---
 rtl/izh_step_scheduler_if.sv | 25 ++
 rtl/izh_step_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_izh_step_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/izh_step_scheduler_if.sv
// Datapath link between izh_step_scheduler and the shared calc_dv/calc_dw pair.
//   master (scheduler side): drives dp_valid, dp_idx, dp_v, dp_w; receives dp_dv, dp_dw
//   slave  (datapath side) : receives operands; drives dp_dv, dp_dw (already scaled by dt)
// All words are N-bit sign-magnitude (bit N-1 = sign).
interface izh_step_scheduler_if #(
  parameter int N  = 32,
  parameter int IW = 2
);
  logic          dp_valid;
  logic [IW-1:0] dp_idx;
  logic [N-1:0]  dp_v;
  logic [N-1:0]  dp_w;
  logic [N-1:0]  dp_dv;
  logic [N-1:0]  dp_dw;

  modport master (
    output dp_valid, dp_idx, dp_v, dp_w,
    input  dp_dv, dp_dw
  );

  modport slave (
    input  dp_valid, dp_idx, dp_v, dp_w,
    output dp_dv, dp_dw
  );
endinterface

// File: rtl/izh_step_scheduler.sv
// izh_step_scheduler: time-multiplexes one shared Izhikevich derivative datapath
// across NEURONS neurons. Holds per-neuron v/w, issues each neuron's operands in
// turn, integrates dv/dw with saturating sign-magnitude adds, applies the spike
// reset rule and reports spikes; one population step per start pulse.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, busy, done   step request, step in progress, 1-cycle completion pulse
//   cfg_we/idx/v/w      initial-state write (ignored while busy)
//   rd_idx, rd_v, rd_w  combinational state readback
//   c, d, v_th          post-spike v value, post-spike w increment, spike threshold
//   dp                  datapath link (izh_step_scheduler_if.master)
//   spike_valid/idx     1-cycle pulse naming the neuron that fired
//   spike_count         spikes in last completed step (only with SPIKE_COUNT_EN)
//
// Optional feature macro: SPIKE_COUNT_EN adds the spike counter and spike_count port.
module izh_step_scheduler #(
  parameter int N       = 32,
  parameter int Q       = 16,
  parameter int NEURONS = 4,
  parameter int DP_LAT  = 1,
  localparam int IW     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 cfg_we,
  input  logic [IW-1:0]        cfg_idx,
  input  logic [N-1:0]         cfg_v,
  input  logic [N-1:0]         cfg_w,
  input  logic [IW-1:0]        rd_idx,
  output logic [N-1:0]         rd_v,
  output logic [N-1:0]         rd_w,
  input  logic [N-1:0]         c,
  input  logic [N-1:0]         d,
  input  logic [N-1:0]         v_th,
  izh_step_scheduler_if.master dp,
  output logic                 spike_valid,
  output logic [IW-1:0]        spike_idx
`ifdef SPIKE_COUNT_EN
  ,
  output logic [IW:0]          spike_count
`endif
);

  if (Q > N - 1) begin : g_bad_q
    $error("Q exceeds the magnitude width N-1");
  end

  localparam int            LW     = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [IW:0]   NCOUNT = (IW + 1)'(NEURONS);
  localparam logic [IW-1:0] LAST   = IW'(NEURONS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [LW-1:0] wait_cnt;
  logic [N-1:0]  v_mem [NEURONS];
  logic [N-1:0]  w_mem [NEURONS];
`ifdef SPIKE_COUNT_EN
  logic [IW:0]   spk_cnt;
`endif

  // Sign-magnitude add; magnitude saturates at all-ones, a zero result is always +0.
  function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic         sgn;
    sum = '0;
    if (a[N-1] == b[N-1]) begin
      sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
      mag = sum[N-1] ? '1 : sum[N-2:0];
      sgn = a[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      mag = a[N-2:0] - b[N-2:0];
      sgn = a[N-1];
    end else begin
      mag = b[N-2:0] - a[N-2:0];
      sgn = b[N-1];
    end
    if (mag == '0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

  // a >= b on signed values; -0 is treated as non-negative zero.
  function automatic logic sm_ge(input logic [N-1:0] a, input logic [N-1:0] b);
    logic a_neg;
    logic b_neg;
    a_neg = a[N-1] && (a[N-2:0] != '0);
    b_neg = b[N-1] && (b[N-2:0] != '0);
    if (a_neg != b_neg) return b_neg;
    if (!a_neg)         return a[N-2:0] >= b[N-2:0];
    return a[N-2:0] <= b[N-2:0];
  endfunction

  logic [N-1:0] v_upd;
  logic [N-1:0] w_upd;
  logic [N-1:0] w_spk;
  logic         fire;

  // Operands are held in dp_v/dp_w through UPDATE, so they double as the old state.
  always_comb begin
    v_upd = sm_add(dp.dp_v, dp.dp_dv);
    w_upd = sm_add(dp.dp_w, dp.dp_dw);
    w_spk = sm_add(w_upd, d);
    fire  = sm_ge(v_upd, v_th);
  end

  always_comb begin
    rd_v = '0;
    rd_w = '0;
    if ({1'b0, rd_idx} < NCOUNT) begin
      rd_v = v_mem[rd_idx];
      rd_w = w_mem[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NEURONS; i++) begin
        v_mem[i] <= '0;
        w_mem[i] <= '0;
      end
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dp.dp_valid <= 1'b0;
      dp.dp_idx   <= '0;
      dp.dp_v     <= '0;
      dp.dp_w     <= '0;
      spike_valid <= 1'b0;
      spike_idx   <= '0;
`ifdef SPIKE_COUNT_EN
      spk_cnt     <= '0;
      spike_count <= '0;
`endif
    end else begin
      done        <= 1'b0;
      spike_valid <= 1'b0;
      dp.dp_valid <= 1'b0;

      if (cfg_we && !busy && ({1'b0, cfg_idx} < NCOUNT)) begin
        v_mem[cfg_idx] <= cfg_v;
        w_mem[cfg_idx] <= cfg_w;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            idx         <= '0;
            dp.dp_valid <= 1'b1;
            dp.dp_idx   <= '0;
            // Forward a same-cycle cfg write to neuron 0 so the step sees the new value.
            if (cfg_we && (cfg_idx == '0)) begin
              dp.dp_v <= cfg_v;
              dp.dp_w <= cfg_w;
            end else begin
              dp.dp_v <= v_mem[0];
              dp.dp_w <= w_mem[0];
            end
`ifdef SPIKE_COUNT_EN
            spk_cnt <= '0;
`endif
          end
        end

        ISSUE: begin
          wait_cnt <= '0;
          state    <= (DP_LAT == 0) ? UPDATE : WAIT;
        end

        WAIT: begin
          if (int'(wait_cnt) == DP_LAT - 1) state <= UPDATE;
          else                              wait_cnt <= wait_cnt + LW'(1);
        end

        UPDATE: begin
          if (fire) begin
            v_mem[idx]  <= c;
            w_mem[idx]  <= w_spk;
            spike_valid <= 1'b1;
            spike_idx   <= idx;
          end else begin
            v_mem[idx]  <= v_upd;
            w_mem[idx]  <= w_upd;
          end
`ifdef SPIKE_COUNT_EN
          spk_cnt <= spk_cnt + (IW + 1)'(fire);
          if (idx == LAST) spike_count <= spk_cnt + (IW + 1)'(fire);
`endif
          if (idx == LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state       <= ISSUE;
            idx         <= idx + IW'(1);
            dp.dp_valid <= 1'b1;
            dp.dp_idx   <= idx + IW'(1);
            dp.dp_v     <= v_mem[idx + IW'(1)];
            dp.dp_w     <= w_mem[idx + IW'(1)];
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_izh_step_scheduler.sv
module tb_izh_step_scheduler;
  localparam int N        = 32;
  localparam int Q        = 16;
  localparam int NEURONS  = 4;
  localparam int DP_LAT   = 1;
  localparam int IW       = 2;
  localparam int STEP_CYC = DP_LAT + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [N-1:0]  cfg_v = '0, cfg_w = '0;
  logic [IW-1:0] rd_idx = '0;
  logic [N-1:0]  rd_v, rd_w;
  logic [N-1:0]  c = '0, d = '0, v_th = '0;
  logic          spike_valid;
  logic [IW-1:0] spike_idx;
`ifdef SPIKE_COUNT_EN
  logic [IW:0]   spike_count;
`endif

  int checks = 0;
  int failures = 0;

  izh_step_scheduler_if #(.N(N), .IW(IW)) dp_if ();

  izh_step_scheduler #(
    .N(N), .Q(Q), .NEURONS(NEURONS), .DP_LAT(DP_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_v(cfg_v), .cfg_w(cfg_w),
    .rd_idx(rd_idx), .rd_v(rd_v), .rd_w(rd_w),
    .c(c), .d(d), .v_th(v_th), .dp(dp_if),
    .spike_valid(spike_valid), .spike_idx(spike_idx)
`ifdef SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  always #5 clk = ~clk;

  // Shared datapath stand-in: result registered one cycle after dp_valid, then held.
  logic [N-1:0] dv_tab [NEURONS];
  logic [N-1:0] dw_tab [NEURONS];
  logic [N-1:0] dv_q, dw_q;
  always @(posedge clk) begin
    if (rst) begin
      dv_q <= 32'h5A5A_1234;
      dw_q <= 32'hA5A5_4321;
    end else if (dp_if.dp_valid) begin
      dv_q <= dv_tab[dp_if.dp_idx];
      dw_q <= dw_tab[dp_if.dp_idx];
    end
  end
  assign dp_if.dp_dv = dv_q;
  assign dp_if.dp_dw = dw_q;

  // Reference model state.
  logic [N-1:0] mv [NEURONS];
  logic [N-1:0] mw [NEURONS];

  function automatic longint sm2i(input logic [N-1:0] x);
    longint m;
    m = longint'(x[N-2:0]);
    return x[N-1] ? -m : m;
  endfunction

  function automatic logic [N-1:0] i2sm(input longint x);
    longint m;
    longint lim;
    logic [N-1:0] r;
    lim = (longint'(1) <<< (N - 1)) - 1;
    m = (x < 0) ? -x : x;
    if (m > lim) m = lim;
    r[N-2:0] = m[N-2:0];
    r[N-1]   = (x < 0) && (m != 0);
    return r;
  endfunction

  function automatic logic [N-1:0] madd(input logic [N-1:0] a, input logic [N-1:0] b);
    return i2sm(sm2i(a) + sm2i(b));
  endfunction

  function automatic logic [N-1:0] rnd_sm(input int unsigned range_int);
    logic [N-1:0] r;
    if ($urandom_range(0, 7) == 0) begin
      r = $urandom;
    end else begin
      r[N-2:0] = (N - 1)'($urandom_range(0, range_int << Q));
      r[N-1]   = 1'($urandom_range(0, 1));
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NEURONS; i++) begin
      rd_idx = IW'(i);
      #1;
      check({tag, "_v"}, rd_v, mv[i]);
      check({tag, "_w"}, rd_w, mw[i]);
    end
  endtask

  task automatic cfg_write(input int idx, input logic [N-1:0] v, input logic [N-1:0] w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_v = v; cfg_w = w;
    @(negedge clk);
    cfg_we = 1'b0;
    mv[idx] = v;
    mw[idx] = w;
  endtask

  task automatic run_step(input bit interfere, input bit co_write, input int abort_at);
    logic [N-1:0] pv [NEURONS];
    logic [N-1:0] pw [NEURONS];
    logic [N-1:0] nv [NEURONS];
    logic [N-1:0] nw [NEURONS];
    int exp_k[$];
    int exp_i[$];
    int n_spk, n_dp, got_k, got_i, extra;
    bit seen_done;
    n_spk = 0; n_dp = 0; seen_done = 0; extra = 0;

    @(negedge clk);
    if (co_write) begin
      int ci;
      ci = $urandom_range(0, NEURONS - 1);
      cfg_we = 1'b1; cfg_idx = IW'(ci); cfg_v = rnd_sm(60); cfg_w = rnd_sm(20);
      mv[ci] = cfg_v;
      mw[ci] = cfg_w;
    end
    start = 1'b1;

    for (int i = 0; i < NEURONS; i++) begin
      logic [N-1:0] vp, wp;
      pv[i] = mv[i];
      pw[i] = mw[i];
      vp = madd(mv[i], dv_tab[i]);
      wp = madd(mw[i], dw_tab[i]);
      if (sm2i(vp) >= sm2i(v_th)) begin
        nv[i] = c;
        nw[i] = madd(wp, d);
        exp_k.push_back((i + 1) * STEP_CYC + 1);
        exp_i.push_back(i);
        n_spk++;
      end else begin
        nv[i] = vp;
        nw[i] = wp;
      end
    end

    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_we = 1'b0;

    for (int k = 1; k <= NEURONS * STEP_CYC + 8; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_spike", spike_valid, 0);
        check("abort_dp_valid", dp_if.dp_valid, 0);
        for (int i = 0; i < NEURONS; i++) begin
          mv[i] = '0;
          mw[i] = '0;
        end
        check_all("abort_rd");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (NEURONS * STEP_CYC + 4) begin
          @(negedge clk);
          if (done || busy || dp_if.dp_valid) extra++;
        end
        check("abort_quiet", extra, 0);
        return;
      end
      if (k == 1) check("busy_rise", busy, 1);
      if (interfere && k == 5) begin
        start = 1'b1;
        cfg_we = 1'b1; cfg_idx = IW'($urandom_range(0, NEURONS - 1));
        cfg_v = rnd_sm(100); cfg_w = rnd_sm(100);
      end
      if (interfere && k == 6) begin
        start = 1'b0;
        cfg_we = 1'b0;
      end
      if (dp_if.dp_valid) begin
        check("dp_valid_cycle", k, 1 + n_dp * STEP_CYC);
        check("dp_idx", dp_if.dp_idx, n_dp);
        if (n_dp < NEURONS) begin
          check("dp_v", dp_if.dp_v, pv[n_dp]);
          check("dp_w", dp_if.dp_w, pw[n_dp]);
        end
        n_dp++;
      end
      if (spike_valid) begin
        if (exp_k.size() == 0) begin
          check("spike_unexpected", spike_valid, 0);
        end else begin
          got_k = exp_k.pop_front();
          got_i = exp_i.pop_front();
          check("spike_cycle", k, got_k);
          check("spike_idx", spike_idx, got_i);
        end
      end
      if (done) begin
        check("done_cycle", k, NEURONS * STEP_CYC + 1);
`ifdef SPIKE_COUNT_EN
        check("spike_count", spike_count, n_spk);
`endif
        seen_done = 1;
        break;
      end
    end
    if (!seen_done) check("done_timeout", done, 1);
    check("spike_missing", exp_k.size(), 0);
    check("issue_count", n_dp, NEURONS);

    @(negedge clk);
    check("busy_fall", busy, 0);
    repeat (4) begin
      @(negedge clk);
      if (done || busy || dp_if.dp_valid) extra++;
    end
    check("post_idle", extra, 0);

    for (int i = 0; i < NEURONS; i++) begin
      mv[i] = nv[i];
      mw[i] = nw[i];
    end
    check_all("step_rd");
  endtask

  task automatic rd_check(input string tag, input int idx, input logic [N-1:0] ev, input logic [N-1:0] ew);
    rd_idx = IW'(idx);
    #1;
    check({tag, "_v"}, rd_v, ev);
    check({tag, "_w"}, rd_w, ew);
  endtask

  initial begin
    for (int i = 0; i < NEURONS; i++) begin
      mv[i] = '0; mw[i] = '0; dv_tab[i] = '0; dw_tab[i] = '0;
    end

    // Power-on reset.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dp_valid", dp_if.dp_valid, 0);
    check("rst_spike", spike_valid, 0);
    check("rst_spike_idx", spike_idx, 0);
    check("rst_dp_idx", dp_if.dp_idx, 0);
    check("rst_dp_v", dp_if.dp_v, 0);
    check_all("rst_rd");

    // Asynchronous reset clears loaded state without waiting for a clock edge.
    for (int i = 0; i < NEURONS; i++) cfg_write(i, rnd_sm(50), rnd_sm(50));
    check_all("cfg_rd");
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < NEURONS; i++) begin
      mv[i] = '0; mw[i] = '0;
    end
    #1;
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_spike", spike_valid, 0);
    check_all("async_rd");
    @(negedge clk);
    rst = 1'b0;

    // Directed: decay without spike, spike with reset, saturation, -0 normalisation.
    c = 32'h8041_0000; d = 32'h0008_0000; v_th = 32'h001E_0000;
    cfg_write(0, 32'h8041_0000, 32'h0000_0000);
    cfg_write(1, 32'h001D_0000, 32'h0000_0000);
    cfg_write(2, 32'h8001_0000, 32'h7FFF_0000);
    cfg_write(3, 32'h0000_0000, 32'h0000_0000);
    dv_tab[0] = 32'h0001_0000; dw_tab[0] = 32'h0000_0000;
    dv_tab[1] = 32'h0002_0000; dw_tab[1] = 32'h0000_0000;
    dv_tab[2] = 32'h0001_0000; dw_tab[2] = 32'h0002_0000;
    dv_tab[3] = 32'h0000_0000; dw_tab[3] = 32'h0000_0000;
    run_step(0, 0, 0);
    rd_check("dir_n0", 0, 32'h8040_0000, 32'h0000_0000);
    rd_check("dir_n1", 1, 32'h8041_0000, 32'h0008_0000);
    rd_check("dir_n2", 2, 32'h0000_0000, 32'h7FFF_FFFF);

    // Second start and cfg write during a step are ignored.
    for (int i = 0; i < NEURONS; i++) begin
      dv_tab[i] = rnd_sm(20); dw_tab[i] = rnd_sm(5);
    end
    run_step(1, 0, 0);

    // Two firing neurons, one exactly at threshold; -0 operand normalises to +0.
    v_th = 32'h000A_0000;
    cfg_write(0, 32'h0014_0000, 32'h0001_0000);
    cfg_write(1, 32'h8000_0000, 32'h0000_0000);
    cfg_write(2, 32'h8005_0000, 32'h0000_0000);
    cfg_write(3, 32'h000A_0000, 32'h8002_0000);
    for (int i = 0; i < NEURONS; i++) begin
      dv_tab[i] = '0; dw_tab[i] = '0;
    end
    run_step(0, 0, 0);
    rd_check("fire_n1", 1, 32'h0000_0000, 32'h0000_0000);
    rd_check("fire_n3", 3, 32'h8041_0000, 32'h0006_0000);

    // Reset in the middle of a step.
    for (int i = 0; i < NEURONS; i++) begin
      cfg_write(i, rnd_sm(40), rnd_sm(40));
      dv_tab[i] = rnd_sm(20); dw_tab[i] = rnd_sm(20);
    end
    run_step(0, 0, 6);

    // Randomized steps, sometimes with a cfg write in the start cycle.
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NEURONS; i++) cfg_write(i, rnd_sm(80), rnd_sm(80));
      end
      c    = rnd_sm(80);
      d    = ($urandom_range(0, 5) == 0) ? 32'h7FFF_0000 : rnd_sm(10);
      v_th = rnd_sm(40);
      for (int i = 0; i < NEURONS; i++) begin
        dv_tab[i] = rnd_sm(40);
        dw_tab[i] = rnd_sm(20);
      end
      run_step(0, ($urandom_range(0, 1) == 1), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
